tc_psum_sched: RTL and testbench
================================

Name: tc_psum_sched

Overview:
Job sequencer in front of the tc_psum partial-sum accumulator. It accepts tile beats (TILE_M*TILE_N partial products) from the reduction network over a valid/ready stream and stamps each beat with its row/col tile position. It inserts the column-group change cycles that make tc_psum write back and clear its column buffer, forces the final writeback, then requests the result readout.
Fixed scan order: column group (outer), row tile, k-step (inner).

Parameters:
M, 16, output matrix rows
N, 16, output matrix columns; must be >= 2*TILE_N and a multiple of TILE_N
TILE_M, 4, rows per beat; M must be a multiple of TILE_M
TILE_N, 4, columns per beat
DW_DATA, 8, element width
DW_POS, 4, row/col position width
DW_K, 8, k-step count width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle job start; ignored while busy
cfg_k_steps  in  DW_K  beats per output tile, sampled at start; 0 treated as 1
busy  out  1  job in progress
done  out  1  one-cycle pulse at job completion
s_valid  in  1  beat valid
s_ready  out  1  beat ready
s_data  in  TILE_M*TILE_N*DW_DATA  beat payload, element (i,j) at bits [(i*TILE_N+j)*DW_DATA +: DW_DATA]
psum_row  out  DW_POS  tc_psum row
psum_col  out  DW_POS  tc_psum col
psum_in  out  TILE_M*TILE_N*DW_DATA  tc_psum in
psum_input_en  out  1  tc_psum input_en
psum_out_en  out  1  tc_psum out_en
psum_out_valid  in  1  tc_psum out_valid
perf_stall_cnt  out  32  stall counter (see Optional Feature)

Behaviour:
- Reset values: all psum_* outputs 0, s_ready=0, busy=0, done=0, perf_stall_cnt=0, FSM=IDLE.
- All psum_* outputs, busy and done are registered. s_ready is combinational from the state: 1 only in ACCUM.
- Counters:
  - cg: column group, 0..N/TILE_N-1
  - rt: row tile, 0..M/TILE_M-1
  - kc: k-step, 0..K-1
- IDLE:
  - Drive psum_input_en=0, psum_col=0, psum_row=0, psum_in=0.
  - On start: latch K=max(cfg_k_steps,1), clear counters, busy<=1, go to ACCUM.
- ACCUM, beat accepted (s_valid&s_ready) in cycle t:
  - At t+1: psum_input_en=1, psum_in=s_data, psum_row=rt*TILE_M, psum_col=cg*TILE_N.
  - Advance kc; on wrap advance rt; on rt wrap advance cg.
- ACCUM, no beat accepted:
  - Next cycle drives psum_input_en=1 with psum_in=0, same row/col.
  - Reason: input_en must stay high, otherwise tc_psum resets its col tag and the next beat triggers a spurious writeback.
- Last beat of a group that is not the final group -> BUBBLE, for exactly 1 cycle:
  - Drive psum_col=(cg+1)*TILE_N, psum_in=0, psum_input_en=1.
  - tc_psum writes back the old group and clears its buffer.
  - Return to ACCUM.
- Last beat of the final group -> FLUSH, for 1 cycle:
  - Drive psum_col=0, psum_in=0, psum_input_en=1; this forces the final writeback.
  - Then SETTLE, for 1 cycle: IDLE-style drive (input_en=0, col=0).
  - Then OUT.
- OUT:
  - Hold psum_out_en=1 until psum_out_valid is sampled high.
  - Then psum_out_en<=0, done<=1 for 1 cycle, busy<=0, go to IDLE.
- Beats are never accepted outside ACCUM. s_data is not consumed while s_ready=0.
- Beat count per job is exactly (N/TILE_N)*(M/TILE_M)*K.
- start during busy is ignored, with no state change.
- rst mid-job: immediate return to reset values. Any partial beat is dropped. tc_psum shares the same rst and clears in the same cycle.
- Position arithmetic is truncated to DW_POS bits; parameter constraints keep it in range.

Optional Feature:
- Macro TC_PSUM_SCHED_PERF_EN.
- Defined: perf_stall_cnt counts ACCUM cycles with s_valid=0. It clears on accepted start, saturates at 2^32-1, and holds after done.
- Undefined: perf_stall_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Defaults, K=1, s_valid always high: 16 beats accepted. Exactly 3 BUBBLE cycles, with psum_col 4,8,12. Then FLUSH with col=0, then out_en. done asserts at a fixed cycle count from start; the bench checks that count is stable.
- K=2, beat values all 1: every cell of tc_psum out equals 2 after done; no cell is double counted or lost.
- s_valid toggling 1,0 with K=1: psum_input_en stays 1 on gap cycles with psum_in=0. Final result matches the no-gap run. With TC_PSUM_SCHED_PERF_EN defined, perf_stall_cnt = number of gap cycles in ACCUM.
- cfg_k_steps=0: behaves identically to K=1 (16 beats).
- start pulsed while busy: ignored; beat count and done timing are unchanged.
- rst asserted after 5 beats: all outputs return to reset values next cycle. A fresh job then completes correctly with no stale data.

Source files
------------

// File: rtl/tc_psum_sched.sv
// Job sequencer for the tc_psum accumulator: stamps tile beats with row/col, inserts group-change
// bubbles, forces the final writeback and requests readout. Optional macro: TC_PSUM_SCHED_PERF_EN.
module tc_psum_sched #(
  parameter int M       = 16,
  parameter int N       = 16,
  parameter int TILE_M  = 4,
  parameter int TILE_N  = 4,
  parameter int DW_DATA = 8,
  parameter int DW_POS  = 4,
  parameter int DW_K    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [DW_K-1:0]                    cfg_k_steps,
  output logic                               busy,
  output logic                               done,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [TILE_M*TILE_N*DW_DATA-1:0]   s_data,
  output logic [DW_POS-1:0]                  psum_row,
  output logic [DW_POS-1:0]                  psum_col,
  output logic [TILE_M*TILE_N*DW_DATA-1:0]   psum_in,
  output logic                               psum_input_en,
  output logic                               psum_out_en,
  input  logic                               psum_out_valid,
  output logic [31:0]                        perf_stall_cnt
);
  localparam int BW   = TILE_M*TILE_N*DW_DATA;
  localparam int CG_N = N/TILE_N;
  localparam int RT_N = M/TILE_M;

  typedef enum logic [2:0] {IDLE, ACCUM, BUBBLE, FLUSH, SETTLE, OUT} state_t;

  state_t            state_q, state_d;
  logic [DW_K-1:0]   k_q, k_d, kc_q, kc_d;
  logic [DW_POS-1:0] rt_q, rt_d, cg_q, cg_d;
  logic [DW_POS-1:0] row_q, row_d, col_q, col_d;
  logic [BW-1:0]     in_q, in_d;
  logic              en_q, en_d, out_en_q, out_en_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              beat;

  assign s_ready = (state_q == ACCUM);
  assign beat    = s_valid & s_ready;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    kc_d     = kc_q;
    rt_d     = rt_q;
    cg_d     = cg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    en_d     = 1'b0;
    row_d    = '0;
    col_d    = '0;
    in_d     = '0;
    out_en_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = (cfg_k_steps == '0) ? DW_K'(1) : cfg_k_steps;
          kc_d    = '0;
          rt_d    = '0;
          cg_d    = '0;
          busy_d  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        // input_en stays high on empty cycles so tc_psum keeps its column tag
        en_d  = 1'b1;
        row_d = DW_POS'(rt_q * TILE_M);
        col_d = DW_POS'(cg_q * TILE_N);
        if (beat) begin
          in_d = s_data;
          if (kc_q == k_q - DW_K'(1)) begin
            kc_d = '0;
            if (rt_q == DW_POS'(RT_N-1)) begin
              rt_d = '0;
              if (cg_q == DW_POS'(CG_N-1)) begin
                state_d = FLUSH;
              end else begin
                cg_d    = cg_q + DW_POS'(1);
                state_d = BUBBLE;
              end
            end else begin
              rt_d = rt_q + DW_POS'(1);
            end
          end else begin
            kc_d = kc_q + DW_K'(1);
          end
        end
      end
      BUBBLE: begin
        en_d    = 1'b1;
        col_d   = DW_POS'(cg_q * TILE_N);
        state_d = ACCUM;
      end
      FLUSH: begin
        en_d    = 1'b1;
        state_d = SETTLE;
      end
      SETTLE: begin
        out_en_d = 1'b1;
        state_d  = OUT;
      end
      OUT: begin
        if (psum_out_valid) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          out_en_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      kc_q     <= '0;
      rt_q     <= '0;
      cg_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      in_q     <= '0;
      en_q     <= 1'b0;
      out_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      kc_q     <= kc_d;
      rt_q     <= rt_d;
      cg_q     <= cg_d;
      row_q    <= row_d;
      col_q    <= col_d;
      in_q     <= in_d;
      en_q     <= en_d;
      out_en_q <= out_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign psum_row      = row_q;
  assign psum_col      = col_q;
  assign psum_in       = in_q;
  assign psum_input_en = en_q;
  assign psum_out_en   = out_en_q;
  assign busy          = busy_q;
  assign done          = done_q;

`ifdef TC_PSUM_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start)
      stall_d = '0;
    else if (state_q == ACCUM && !s_valid && stall_q != 32'hFFFF_FFFF)
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else     stall_q <= stall_d;
  end

  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_tc_psum_sched.sv
// Directed bench for tc_psum_sched with a small behavioural tc_psum model that accumulates the
// stamped beats into a result matrix and answers the readout request.
module tb_tc_psum_sched;
  localparam int M = 16, N = 16, TM = 4, TN = 4, DW = 8, DP = 4, DK = 8;
  localparam int BW = TM*TN*DW;

  logic          clk, rst, start, busy, done, s_valid, s_ready;
  logic [DK-1:0] cfg_k_steps;
  logic [BW-1:0] s_data, psum_in;
  logic [DP-1:0] psum_row, psum_col;
  logic          psum_input_en, psum_out_en, psum_out_valid;
  logic [31:0]   perf_stall_cnt;

  tc_psum_sched #(.M(M), .N(N), .TILE_M(TM), .TILE_N(TN), .DW_DATA(DW), .DW_POS(DP), .DW_K(DK)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_k_steps(cfg_k_steps), .busy(busy), .done(done),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .psum_row(psum_row), .psum_col(psum_col),
    .psum_in(psum_in), .psum_input_en(psum_input_en), .psum_out_en(psum_out_en),
    .psum_out_valid(psum_out_valid), .perf_stall_cnt(perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // stimulus state
  bit drv_en = 0, tog = 1;
  int valid_mode = 0, data_mode = 0, kval = 1, beats = 0, stalls = 0;

  // model state
  logic [15:0] res  [M][N];
  logic [15:0] bufm [M][TN];
  logic [DP-1:0] tag;
  bit tag_v = 0, seen_en = 0;
  int ncol = 0, en_gap = 0;
  int col_log [16];

  function automatic logic [BW-1:0] beat_data(input int b);
    logic [BW-1:0] d;
    int rt, cg, v;
    d  = '0;
    rt = (b / kval) % (M/TM);
    cg = b / (kval * (M/TM));
    for (int i = 0; i < TM; i++)
      for (int j = 0; j < TN; j++) begin
        v = data_mode ? ((rt*TM + i)*16 + cg*TN + j) : 1;
        d[(i*TN+j)*DW +: DW] = DW'(v);
      end
    return d;
  endfunction

  initial forever begin
    @(negedge clk);
    if (drv_en) begin
      s_valid = (valid_mode == 0) ? 1'b1 : tog;
      tog     = ~tog;
      s_data  = beat_data(beats);
    end else begin
      s_valid = 1'b0;
      s_data  = '0;
    end
    #4;
    if (!rst && s_ready && !s_valid) stalls++;
    if (!rst && s_valid && s_ready) beats++;
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      tag_v = 0;
      psum_out_valid = 1'b0;
      for (int r = 0; r < M; r++) for (int j = 0; j < TN; j++) bufm[r][j] = '0;
    end else begin
      if (busy && seen_en && !psum_input_en && !psum_out_en) en_gap++;
      if (psum_input_en) begin
        seen_en = 1;
        if (!tag_v || psum_col != tag) begin
          if (tag_v)
            for (int r = 0; r < M; r++)
              for (int j = 0; j < TN; j++) res[r][int'(tag)+j] += bufm[r][j];
          for (int r = 0; r < M; r++) for (int j = 0; j < TN; j++) bufm[r][j] = '0;
          tag = psum_col;
          tag_v = 1;
          if (ncol < 16) col_log[ncol] = int'(psum_col);
          ncol++;
        end
        for (int i = 0; i < TM; i++)
          for (int j = 0; j < TN; j++)
            bufm[int'(psum_row)+i][j] += 16'(psum_in[(i*TN+j)*DW +: DW]);
      end else begin
        tag_v = 0;
        for (int r = 0; r < M; r++) for (int j = 0; j < TN; j++) bufm[r][j] = '0;
      end
      psum_out_valid = psum_out_en && !psum_out_valid;
    end
  end

  task automatic prep(input int k, input int vmode, input int dmode);
    for (int r = 0; r < M; r++) for (int c = 0; c < N; c++) res[r][c] = '0;
    ncol = 0; beats = 0; stalls = 0; en_gap = 0; seen_en = 0; tog = 1;
    valid_mode = vmode; data_mode = dmode; kval = (k == 0) ? 1 : k;
    drv_en = 1;
  endtask

  // cycles from the start-sampling edge to the edge that raises done
  task automatic run_job(input int k, input int vmode, input int dmode, input bit poke, output int cyc);
    prep(k, vmode, dmode);
    @(negedge clk);
    cfg_k_steps = DK'(k);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (cyc < 400) begin
      @(posedge clk);
      cyc++;
      #1;
      start = poke && (cyc == 3 || cyc == 10);
      if (done) break;
    end
    start = 1'b0;
    drv_en = 0;
    if (cyc >= 400) check("done_timeout", 0, 1);
    check("busy_after_done", busy, 0);
  endtask

  function automatic int bad_cells(input int mode, input int k);
    int bad = 0;
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        if (res[r][c] !== 16'(mode ? (r*16 + c) * k : k)) bad++;
    return bad;
  endfunction

  task automatic check_perf(input string tag);
`ifdef TC_PSUM_SCHED_PERF_EN
    check(tag, perf_stall_cnt, stalls);
`else
    check(tag, perf_stall_cnt, 0);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_psum_ctl"}, {psum_input_en, psum_out_en, psum_row, psum_col}, 0);
    check({tag, "_psum_in"}, psum_in, 0);
    check({tag, "_perf"}, perf_stall_cnt, 0);
  endtask

  int cyc, n;

  initial begin
    rst = 1'b1; start = 1'b0; cfg_k_steps = '0; s_valid = 1'b0; s_data = '0; psum_out_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // K=1, always valid
    run_job(1, 0, 1, 0, cyc);
    check("k1_beats", beats, 16);
    check("k1_done_cycles", cyc, 22);
    check("k1_col_changes", ncol, 5);
    check("k1_col_seq", {col_log[0][7:0], col_log[1][7:0], col_log[2][7:0], col_log[3][7:0], col_log[4][7:0]},
          {8'd0, 8'd4, 8'd8, 8'd12, 8'd0});
    check("k1_en_drop", en_gap, 0);
    check("k1_result", bad_cells(1, 1), 0);
    check_perf("k1_perf");

    // K=2, all ones
    run_job(2, 0, 0, 0, cyc);
    check("k2_beats", beats, 32);
    check("k2_result", bad_cells(0, 2), 0);
    check("k2_col_changes", ncol, 5);

    // valid toggling 1,0
    run_job(1, 1, 1, 0, cyc);
    check("gap_beats", beats, 16);
    check("gap_stalls_seen", stalls > 0, 1);
    check("gap_en_drop", en_gap, 0);
    check("gap_result", bad_cells(1, 1), 0);
    check_perf("gap_perf");

    // cfg_k_steps = 0 behaves as K=1
    run_job(0, 0, 1, 0, cyc);
    check("k0_beats", beats, 16);
    check("k0_done_cycles", cyc, 22);
    check("k0_result", bad_cells(1, 1), 0);

    // start pulsed while busy
    run_job(1, 0, 1, 1, cyc);
    check("poke_beats", beats, 16);
    check("poke_done_cycles", cyc, 22);
    check("poke_result", bad_cells(1, 1), 0);

    // reset after 5 beats
    prep(1, 0, 1);
    @(negedge clk);
    cfg_k_steps = DK'(1);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (beats < 5 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reached5", beats >= 5, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 check_idle_outputs("rst_mid");
    @(negedge clk) rst = 1'b0;
    drv_en = 0;
    repeat (2) @(negedge clk);

    run_job(1, 0, 1, 0, cyc);
    check("fresh_beats", beats, 16);
    check("fresh_done_cycles", cyc, 22);
    check("fresh_result", bad_cells(1, 1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
